// File: rtl/neck_ctrl_pkg.sv
// Shared state encodings and stage-ordering helpers for the neck-detection sequencer.
package neck_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    W_ADC,
    W_FILT,
    W_DIF,
    W_JDG,
    FAULT
  } seq_state_e;

  typedef enum logic [1:0] {
    P_OFF,
    P_ON,
    P_CUT
  } pwr_state_e;

  function automatic logic is_wait(seq_state_e s);
    return (s == W_ADC) || (s == W_FILT) || (s == W_DIF) || (s == W_JDG);
  endfunction

  function automatic seq_state_e next_stage(seq_state_e s);
    case (s)
      W_ADC:   return W_FILT;
      W_FILT:  return W_DIF;
      W_DIF:   return W_JDG;
      default: return IDLE;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_timer.sv
// Loadable down-counter that saturates at zero; expired is high while the count is zero.
module ctrl_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= value;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/neck_seq_ctrl.sv
// Sample sequencer with per-stage watchdog and welder power interlock (cut, off-time, blanking).
module neck_seq_ctrl
  import neck_ctrl_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int STAGE_TIMEOUT = 255,
  parameter int OFF_TIME      = 50000,
  parameter int BLANK_SAMPLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        fault_clr,
  output logic        adc_start,
  input  logic        adc_done,
  input  logic        filter_done,
  input  logic        dif_done,
  input  logic        judge_valid,
  input  logic        neck_detect,
  output logic        power_switch,
  output logic        busy,
  output logic        fault,
  output logic        overrun,
  output logic [15:0] sample_cnt
);

  localparam int PW = $clog2(SAMPLE_PERIOD) + 1;
  localparam int TW = $clog2(STAGE_TIMEOUT) + 1;
  localparam int OW = $clog2(OFF_TIME) + 1;
  localparam int BW = $clog2(BLANK_SAMPLES) + 1;

  seq_state_e    seq_q;
  pwr_state_e    pwr_q;
  logic [PW-1:0] per_q;
  logic [BW-1:0] blank_q;
  logic [15:0]   cnt_q;
  logic          adc_start_q, busy_q, fault_q, overrun_q, power_q;
  logic          tick, stage_done, wd_load, wd_en, wd_expired;
  logic          kill, off_load, off_en, off_expired;

  assign tick = enable && (per_q == PW'(SAMPLE_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
    end else if (!enable || tick) begin
      per_q <= '0;
    end else begin
      per_q <= per_q + PW'(1);
    end
  end

  always_comb begin
    stage_done = 1'b0;
    case (seq_q)
      W_ADC:   stage_done = adc_done;
      W_FILT:  stage_done = filter_done;
      W_DIF:   stage_done = dif_done;
      W_JDG:   stage_done = judge_valid;
      default: stage_done = 1'b0;
    endcase
  end

  // Watchdog reloads on every entry into a wait state (from START or a completed stage).
  assign wd_load = (seq_q == START) || (stage_done && (seq_q != W_JDG));
  assign wd_en   = is_wait(seq_q);

  ctrl_timer #(.W(TW)) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (wd_load),
    .value   (TW'(STAGE_TIMEOUT)),
    .en      (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_q       <= IDLE;
      adc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      adc_start_q <= 1'b0;
      if (fault_clr)      overrun_q <= 1'b0;
      if (tick && busy_q) overrun_q <= 1'b1;
      case (seq_q)
        IDLE: if (tick && !fault_q) begin
          seq_q       <= START;
          adc_start_q <= 1'b1;
          busy_q      <= 1'b1;
        end
        START: seq_q <= W_ADC;
        W_ADC, W_FILT, W_DIF, W_JDG: begin
          // A done pulse on the timeout cycle still advances the stage.
          if (stage_done) begin
            seq_q <= next_stage(seq_q);
            if (seq_q == W_JDG) begin
              busy_q <= 1'b0;
              cnt_q  <= cnt_q + 16'd1;
            end
          end else if (wd_expired) begin
            seq_q   <= FAULT;
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        FAULT: if (fault_clr) begin
          seq_q   <= IDLE;
          fault_q <= 1'b0;
        end
        default: seq_q <= IDLE;
      endcase
    end
  end

  assign kill     = fault_q || !enable;
  assign off_load = !kill && (pwr_q == P_ON) && judge_valid && neck_detect && (blank_q == '0);
  assign off_en   = (pwr_q == P_CUT);

  // Loaded with OFF_TIME-1 so expiry on the last low cycle yields exactly OFF_TIME low cycles.
  ctrl_timer #(.W(OW)) u_off (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (off_load),
    .value   (OW'(OFF_TIME - 1)),
    .en      (off_en),
    .expired (off_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwr_q   <= P_OFF;
      power_q <= 1'b0;
      blank_q <= '0;
    end else if (kill) begin
      pwr_q   <= P_OFF;
      power_q <= 1'b0;
    end else begin
      case (pwr_q)
        P_OFF: begin
          pwr_q   <= P_ON;
          power_q <= 1'b1;
          blank_q <= BW'(BLANK_SAMPLES);
        end
        P_ON: if (judge_valid) begin
          if (blank_q != '0) begin
            blank_q <= blank_q - BW'(1);
          end else if (neck_detect) begin
            pwr_q   <= P_CUT;
            power_q <= 1'b0;
          end
        end
        P_CUT: if (off_expired) begin
          pwr_q   <= P_ON;
          power_q <= 1'b1;
          blank_q <= BW'(BLANK_SAMPLES);
        end
        default: begin
          pwr_q   <= P_OFF;
          power_q <= 1'b0;
        end
      endcase
    end
  end

  assign adc_start    = adc_start_q;
  assign busy         = busy_q;
  assign fault        = fault_q;
  assign overrun      = overrun_q;
  assign power_switch = power_q;
  assign sample_cnt   = cnt_q;

endmodule
